// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for a block FFT: fills a sample buffer, starts the core, waits for done
// (with timeout) and drains results, tracking drained frames and sticky error flags.
module fft_frame_ctrl #(
   parameter int unsigned N       = 64,
   parameter int unsigned AW      = 6,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          valid_a,
   output logic          in_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic          fft_start,
   input  logic          fft_done,
   input  logic          rd_en,
   output logic          out_valid,
   output logic [AW-1:0] rd_addr,
   output logic          busy,
   output logic [7:0]    frame_cnt,
   input  logic          err_clr,
   output logic          overflow,
   output logic          timeout_err
);

   typedef enum logic [1:0] {StFill, StStart, StWait, StDrain} state_e;

   localparam logic [AW-1:0] LastAddr = AW'(N - 1);
   localparam logic [15:0]   LastWait = 16'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [15:0]   timer_q, timer_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic          overflow_q, overflow_d;
   logic          timeout_err_q, timeout_err_d;
   logic          accept, drop, to_set;

   always_comb begin
      state_d     = state_q;
      wr_addr_d   = wr_addr_q;
      rd_addr_d   = rd_addr_q;
      timer_d     = timer_q;
      frame_cnt_d = frame_cnt_q;
      to_set      = 1'b0;
      accept      = valid_a && (state_q == StFill);
      drop        = valid_a && (state_q != StFill);

      unique case (state_q)
         StFill: begin
            if (accept) begin
               if (wr_addr_q == LastAddr) begin
                  wr_addr_d = '0;
                  state_d   = StStart;
               end else begin
                  wr_addr_d = wr_addr_q + 1'b1;
               end
            end
         end
         StStart: begin
            timer_d = '0;
            state_d = StWait;
         end
         StWait: begin
            // done wins over a coincident timeout expiry
            if (fft_done) begin
               rd_addr_d = '0;
               state_d   = StDrain;
            end else if (timer_q == LastWait) begin
               to_set  = 1'b1;
               state_d = StFill;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         StDrain: begin
            if (rd_en) begin
               if (rd_addr_q == LastAddr) begin
                  rd_addr_d   = '0;
                  frame_cnt_d = frame_cnt_q + 8'd1;
                  state_d     = StFill;
               end else begin
                  rd_addr_d = rd_addr_q + 1'b1;
               end
            end
         end
         default: state_d = StFill;
      endcase

      // set events take precedence over err_clr
      overflow_d    = drop   ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
      timeout_err_d = to_set ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= StFill;
         wr_addr_q     <= '0;
         rd_addr_q     <= '0;
         timer_q       <= '0;
         frame_cnt_q   <= '0;
         overflow_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         rd_addr_q     <= rd_addr_d;
         timer_q       <= timer_d;
         frame_cnt_q   <= frame_cnt_d;
         overflow_q    <= overflow_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      in_ready    = (state_q == StFill);
      wr_en       = valid_a & in_ready;
      wr_addr     = wr_addr_q;
      fft_start   = (state_q == StStart);
      out_valid   = (state_q == StDrain);
      rd_addr     = rd_addr_q;
      busy        = (state_q != StFill);
      frame_cnt   = frame_cnt_q;
      overflow    = overflow_q;
      timeout_err = timeout_err_q;
   end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: directed scenarios then random traffic, every cycle compared
// against a frame-progress reference model.
module tb_fft_frame_ctrl;

   localparam int N       = 64;
   localparam int AW      = 6;
   localparam int TIMEOUT = 255;

   logic          CLK = 1'b0;
   logic          RST, valid_a, fft_done, rd_en, err_clr;
   logic          in_ready, wr_en, fft_start, out_valid, busy, overflow, timeout_err;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [7:0]    frame_cnt;

   int tests = 0;
   int fails = 0;

   fft_frame_ctrl #(.N(N), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .valid_a     (valid_a),
      .in_ready    (in_ready),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .fft_start   (fft_start),
      .fft_done    (fft_done),
      .rd_en       (rd_en),
      .out_valid   (out_valid),
      .rd_addr     (rd_addr),
      .busy        (busy),
      .frame_cnt   (frame_cnt),
      .err_clr     (err_clr),
      .overflow    (overflow),
      .timeout_err (timeout_err)
   );

   always #5 CLK = ~CLK;

   // Reference model: which phase the frame is in, how many samples are stored, how many
   // results have been consumed, how long the core has been waited on.
   string m_phase      = "fill";
   int    m_stored     = 0;
   int    m_consumed   = 0;
   int    m_waited     = 0;
   int    m_frames     = 0;
   bit    m_overflow   = 0;
   bit    m_timeout    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      bit filling;
      filling = (m_phase == "fill");
      chk("in_ready",    32'(in_ready),    32'(filling));
      chk("wr_en",       32'(wr_en),       32'(filling && valid_a));
      chk("wr_addr",     32'(wr_addr),     32'(m_stored));
      chk("fft_start",   32'(fft_start),   32'(m_phase == "start"));
      chk("out_valid",   32'(out_valid),   32'(m_phase == "drain"));
      chk("rd_addr",     32'(rd_addr),     32'(m_consumed));
      chk("busy",        32'(busy),        32'(!filling));
      chk("frame_cnt",   32'(frame_cnt),   32'(m_frames));
      chk("overflow",    32'(overflow),    32'(m_overflow));
      chk("timeout_err", 32'(timeout_err), 32'(m_timeout));
   endtask

   task automatic model_edge(input bit r, input bit v, input bit d, input bit re, input bit c);
      bit ov_set, to_set;
      ov_set = 0;
      to_set = 0;
      if (r) begin
         m_phase = "fill"; m_stored = 0; m_consumed = 0; m_waited = 0;
         m_frames = 0; m_overflow = 0; m_timeout = 0;
         return;
      end
      if (v && m_phase != "fill") ov_set = 1;
      if (m_phase == "fill") begin
         if (v) begin
            m_stored = m_stored + 1;
            if (m_stored == N) begin
               m_stored = 0;
               m_phase  = "start";
            end
         end
      end else if (m_phase == "start") begin
         m_waited = 0;
         m_phase  = "wait";
      end else if (m_phase == "wait") begin
         // m_waited counts WAIT cycles already elapsed; this is WAIT cycle m_waited+1
         if (d) begin
            m_consumed = 0;
            m_phase    = "drain";
         end else if (m_waited + 1 == TIMEOUT) begin
            to_set  = 1;
            m_phase = "fill";
         end else begin
            m_waited = m_waited + 1;
         end
      end else begin
         if (re) begin
            m_consumed = m_consumed + 1;
            if (m_consumed == N) begin
               m_consumed = 0;
               m_frames   = (m_frames + 1) % 256;
               m_phase    = "fill";
            end
         end
      end
      m_overflow = ov_set ? 1'b1 : (c ? 1'b0 : m_overflow);
      m_timeout  = to_set ? 1'b1 : (c ? 1'b0 : m_timeout);
   endtask

   // Drive one cycle: apply inputs after the falling edge, compare, then clock the model.
   task automatic cyc(input bit r, input bit v, input bit d, input bit re, input bit c);
      RST = r; valid_a = v; fft_done = d; rd_en = re; err_clr = c;
      #1;
      check_outputs();
      @(posedge CLK);
      model_edge(r, v, d, re, c);
      @(negedge CLK);
   endtask

   task automatic fill(input int n);
      for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   initial begin
      RST = 1; valid_a = 0; fft_done = 0; rd_en = 0; err_clr = 0;
      @(negedge CLK);
      cyc(1, 0, 0, 0, 0);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_busy",     32'(busy),     32'd0);
      chk("reset_wr_addr",  32'(wr_addr),  32'd0);

      // Back-to-back frame, done 5 cycles after start, rd_en held high
      fill(N);
      chk("start_after_fill", 32'(fft_start), 32'd1);
      idle(5);
      cyc(0, 0, 1, 0, 0);
      chk("drain_entered", 32'(out_valid), 32'd1);
      for (int i = 0; i < N; i++) cyc(0, 0, 0, 1, 0);
      chk("frame_cnt_one", 32'(frame_cnt), 32'd1);
      chk("no_errors",     32'({overflow, timeout_err}), 32'd0);

      // rd_en toggling during drain
      fill(N);
      idle(2);
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 2 * N; i++) cyc(0, 0, 0, (i % 2) == 0, 0);
      chk("toggle_frame_done", 32'(frame_cnt), 32'd2);
      chk("toggle_back_fill",  32'(in_ready),  32'd1);

      // Core never answers: timeout after TIMEOUT wait cycles
      fill(N);
      idle(1);
      idle(TIMEOUT - 1);
      chk("pre_timeout_busy", 32'(busy), 32'd1);
      idle(1);
      chk("timeout_set",   32'(timeout_err), 32'd1);
      chk("timeout_fill",  32'(in_ready),    32'd1);
      chk("timeout_frames", 32'(frame_cnt),  32'd2);
      cyc(0, 0, 0, 0, 1);
      chk("timeout_cleared", 32'(timeout_err), 32'd0);

      // Sample during WAIT is dropped; err_clr loses to a same-cycle overflow
      fill(N);
      idle(1);
      cyc(0, 1, 0, 0, 0);
      chk("ovf_set", 32'(overflow), 32'd1);
      RST = 0; valid_a = 1; err_clr = 1; fft_done = 0; rd_en = 0;
      #1;
      chk("ovf_wr_en_low", 32'(wr_en), 32'd0);
      @(negedge CLK);
      model_edge(0, 1, 0, 0, 1);
      chk("ovf_beats_clr", 32'(overflow), 32'd1);
      cyc(0, 0, 1, 0, 1);
      chk("ovf_cleared", 32'(overflow), 32'd0);
      for (int i = 0; i < N; i++) cyc(0, 0, 0, 1, 0);

      // Reset mid-fill restarts the frame
      fill(30);
      cyc(1, 0, 0, 0, 0);
      chk("rst_mid_wr_addr", 32'(wr_addr), 32'd0);
      fill(N - 1);
      chk("no_early_start", 32'(fft_start), 32'd0);
      fill(1);
      chk("start_after_new", 32'(fft_start), 32'd1);
      cyc(1, 0, 0, 0, 1);
      chk("rst_in_start", 32'({fft_start, out_valid, busy}), 32'd0);

      // Stray done during fill ignored; done on last timeout cycle wins
      fill(10);
      cyc(0, 1, 1, 0, 0);
      fill(N - 12);
      cyc(0, 0, 1, 1, 0);
      fill(1);
      chk("stray_done_start", 32'(fft_start), 32'd1);
      idle(1);
      idle(TIMEOUT - 1);
      cyc(0, 0, 1, 0, 0);
      chk("late_done_drain", 32'(out_valid),   32'd1);
      chk("late_done_noerr", 32'(timeout_err), 32'd0);
      for (int i = 0; i < N; i++) cyc(0, 0, 0, 1, 0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(399) == 0),
             ($urandom_range(99) < 70),
             ($urandom_range(99) < 4),
             ($urandom_range(99) < 60),
             ($urandom_range(99) < 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
